// File: rtl/utils.sv
// Shared integer-pipeline types and encodings: issue-queue entry layout,
// opcode/func constants and datapath widths.
package utils;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 7;

    localparam logic [OPC_W-1:0] OPC_BUBBLE  = 7'b0000000;
    localparam logic [OPC_W-1:0] R_TYPE      = 7'b0110011;
    localparam logic [OPC_W-1:0] I_TYPE      = 7'b0010011;
    localparam logic [OPC_W-1:0] LUI_TYPE    = 7'b0110111;
    localparam logic [OPC_W-1:0] BRANCH_TYPE = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_OR  = 3'd6;
    localparam logic [2:0] F3_AND = 3'd7;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    typedef struct packed {
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;  // immediate for I-type and LUI
        logic [TAG_W-1:0]  rd_tag;
    } common_fifo_data;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        common_fifo_data  common_data;
    } int_fifo_data;

endpackage

// File: rtl/int_alu.sv
// Combinational integer ALU: R/I-type logic and add/sub, LUI pass-through
// and BEQ/BNE resolution.
module int_alu
    import utils::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              is_branch,
    output logic              taken
);

    always_comb begin
        result    = '0;
        is_branch = 1'b0;
        taken     = 1'b0;
        case (opcode)
            R_TYPE: begin
                case (func3)
                    F3_ADD: begin
                        if (func7 == F7_BASE)     result = a + b;
                        else if (func7 == F7_SUB) result = a - b;
                    end
                    F3_XOR:  result = a ^ b;
                    F3_OR:   result = a | b;
                    F3_AND:  result = a & b;
                    default: result = '0;
                endcase
            end
            I_TYPE: begin
                case (func3)
                    F3_ADD:  result = a + b;
                    F3_XOR:  result = a ^ b;
                    F3_OR:   result = a | b;
                    F3_AND:  result = a & b;
                    default: result = '0;
                endcase
            end
            LUI_TYPE: result = b;
            BRANCH_TYPE: begin
                is_branch = 1'b1;
                case (func3)
                    F3_BEQ:  taken = (a == b);
                    F3_BNE:  taken = (a != b);
                    default: taken = 1'b0;
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/int_exec_unit.sv
// Integer execution unit: pops the FWFT issue queue, executes in the pop
// cycle and holds the result in a one-entry register until the CDB grants.
module int_exec_unit
    import utils::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_iq_empty,
    input  int_fifo_data      i_iq_data,
    output logic              o_iq_rd_en,
    output logic              o_cdb_req,
    input  logic              i_cdb_grant,
    output logic              o_cdb_valid,
    output logic [TAG_W-1:0]  o_cdb_tag,
    output logic [DATA_W-1:0] o_cdb_data,
    output logic              o_cdb_branch,
    output logic              o_cdb_branch_taken
);

    logic              full;
    logic              res_is_branch;
    logic              res_taken;
    logic [TAG_W-1:0]  res_tag;
    logic [DATA_W-1:0] res_data;

    logic [DATA_W-1:0] alu_result;
    logic              alu_is_branch;
    logic              alu_taken;
    logic              fire;
    logic              pop;

    int_alu u_alu (
        .opcode    (i_iq_data.opcode),
        .func3     (i_iq_data.func3),
        .func7     (i_iq_data.func7),
        .a         (i_iq_data.common_data.rs1_data),
        .b         (i_iq_data.common_data.rs2_data),
        .result    (alu_result),
        .is_branch (alu_is_branch),
        .taken     (alu_taken)
    );

    // Handshake: req mirrors a full register; a broadcast happens in any cycle
    // where req and grant are both high, and the slot may be refilled from the
    // queue on that same edge. Reset masks everything so a pending result dies.
    assign o_cdb_req  = full & ~rst;
    assign fire       = o_cdb_req & i_cdb_grant;
    assign pop        = ~rst & ~i_iq_empty & (~full | fire);
    assign o_iq_rd_en = pop;

    assign o_cdb_valid        = fire & ~res_is_branch;
    assign o_cdb_branch       = fire & res_is_branch;
    assign o_cdb_branch_taken = fire & res_is_branch & res_taken;
    assign o_cdb_tag          = fire ? res_tag  : '0;
    assign o_cdb_data         = fire ? res_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            full          <= 1'b0;
            res_is_branch <= 1'b0;
            res_taken     <= 1'b0;
            res_tag       <= '0;
            res_data      <= '0;
        end else begin
            if (fire) full <= 1'b0;
            // Opcode 0 is a bubble: consumed from the queue, never broadcast.
            if (pop && i_iq_data.opcode != OPC_BUBBLE) begin
                full          <= 1'b1;
                res_is_branch <= alu_is_branch;
                res_taken     <= alu_taken;
                res_tag       <= i_iq_data.common_data.rd_tag;
                res_data      <= alu_is_branch ? '0 : alu_result;
            end
        end
    end

endmodule

// File: doc/int_exec_unit.md
# int_exec_unit

Integer execution unit sitting directly downstream of the dispatcher's integer issue queue. Pops the queue head (first-word-fall-through), executes R-type ALU, I-type ALU, LUI and BEQ/BNE operations, and holds the result in a one-entry output register until the CDB arbiter grants a broadcast slot. Branch outcomes travel on the same CDB slot, flagged as branch results, so the dispatcher can release its branch lock and flush on a taken branch.

## Interface
- No parameters. Widths are fixed by the shared package: tag 6 bits, data 32 bits.
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- i_iq_empty  in  1  integer issue queue empty.
- i_iq_data  in  int_fifo_data  queue head, valid whenever !i_iq_empty. Fields used: opcode, func3, func7, common_data.rs1_data, common_data.rs2_data (immediate for I/LUI), common_data.rd_tag.
- o_iq_rd_en  out  1  pop strobe. Head is consumed on the same edge.
- o_cdb_req  out  1  result register holds a pending broadcast.
- i_cdb_grant  in  1  arbiter grant, combinational in the same cycle as o_cdb_req.
- o_cdb_valid  out  1  data broadcast this cycle (non-branch).
- o_cdb_tag  out  6  destination tag.
- o_cdb_data  out  32  result.
- o_cdb_branch  out  1  branch resolution broadcast this cycle.
- o_cdb_branch_taken  out  1  branch outcome; meaningful only with o_cdb_branch.

## Operation
- Result register fields: full, is_branch, taken, tag, data.
- o_iq_rd_en = !i_iq_empty & (!full | (o_cdb_req & i_cdb_grant)).
- On pop with opcode == 0: bubble. Entry is dropped, full is not set.
- On pop with any other opcode: execute in the pop cycle and load the register on the edge, with full = 1.
- R_TYPE (7'b0110011):
  - func3 0 with func7 0x00 is ADD; with func7 0x20 is SUB; any other func7 gives 0.
  - func3 4 XOR, func3 6 OR, func3 7 AND.
  - Other func3 gives 0.
- I_TYPE (7'b0010011): func3 0 ADDI, 4 XORI, 6 ORI, 7 ANDI, others 0. The b operand is rs2_data.
- LUI (7'b0110111): result = rs2_data, passed through.
- BRANCH (7'b1100011): func3 0 BEQ (taken = a==b), func3 1 BNE (taken = a!=b), other func3 not taken. is_branch = 1, data = 0.
- Any other opcode: data result 0, still broadcast.
- Arithmetic is 32-bit modulo with no overflow flag.
- Broadcast cycle (full & i_cdb_grant):
  - o_cdb_valid = !is_branch; o_cdb_branch = is_branch.
  - o_cdb_tag and o_cdb_data come from the register.
  - full clears on the edge unless a new pop reloads it.
- When not granted, all o_cdb_* outputs are 0. The register holds its value and o_cdb_req stays high.
- o_cdb_valid and o_cdb_branch are never high together.

## Timing
- Reset values: full = 0. All outputs are 0, including o_iq_rd_en, which is forced low while rst is high.
- Latency: pop at edge N, o_cdb_req high in cycle N+1, earliest broadcast in cycle N+1.
- Throughput: one op per cycle under continuous grant. Pop and broadcast in the same cycle is legal; the register reloads.
- Queue empty: no pop, register drains normally.
- Register full with no grant: no pop. The queue head is held untouched, giving back-pressure.
- Grant without request: ignored.
- rst asserted mid-operation: the pending result is discarded and not broadcast. The queue entry is already consumed; the dispatcher is reset in the same cycle.
- Taken branch: reported exactly once. Younger integer ops are never present because the dispatcher locks dispatch behind branches, so no flush input is needed.

## Structure
- Shared package (utils.sv) holds:
  - int_fifo_data and common_fifo_data typedefs.
  - Opcode constants R_TYPE, I_TYPE, LUI_TYPE, BRANCH_TYPE.
  - func3/func7 constants and the tag width.
- Sub-module int_alu: purely combinational. Inputs opcode/func3/func7/a/b; outputs result, is_branch, taken.
- int_exec_unit holds the pop logic, the result register and the CDB handshake only.

## Test plan
- ADDI, rs1 = 0, imm = 4, tag 5, grant tied high:
  - Pop at edge N.
  - Cycle N+1: o_cdb_valid = 1, tag = 5, data = 0x00000004.
- LUI rs2_data = 0x10010000, tag 17:
  - Broadcast data = 0x10010000.
  - SUB 3−4: data = 0xFFFFFFFF.
  - Unknown R func7 (0x01) with func3 0: data = 0.
- BNE with a = 3, b = 3, then BEQ with a = 3, b = 3:
  - First broadcast: o_cdb_branch = 1, taken = 0, o_cdb_valid = 0.
  - Second broadcast: taken = 1.
- Grant held low for 5 cycles with 3 queued ops:
  - Exactly one pop; o_cdb_req is steady and the outputs stay 0.
  - After the grant rises: three consecutive broadcasts in order, one per cycle, with no loss or duplication.
- Opcode-0 entries interleaved with ADD 2+3:
  - Each opcode-0 entry is popped with no broadcast.
  - The ADD broadcasts 0x00000005.
- rst asserted while full with grant low:
  - The next cycle has o_cdb_req = 0 and no broadcast.
  - After reset, a new op executes normally.
